// File: rtl/instr_mem_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : instr_mem_loader                                                  |
// | Function : Length-prefixed byte-stream loader for the instruction memory.    |
// |            Optional trailing checksum enabled by macro LOADER_CHECKSUM_EN.   |
// | Revision : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module instr_mem_loader #(
  parameter int DEPTH      = 36,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [7:0]            DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic [ADDR_WIDTH-1:0] WR_ADDRESS,
  output logic [7:0]            WR_DATA,
  output logic                  WR_EN,
  output logic                  CPU_HOLD,
  output logic                  DONE,
  output logic                  ERROR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_FINISH = 3'd5
  } state_t;

  localparam logic [31:0] c_depth = 32'(DEPTH);

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_wr_en;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_din_ready;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_wr;
  logic                  w_set_done;
  logic                  w_set_error;
  logic [15:0]           w_len;
  logic [ADDR_WIDTH-1:0] w_count_inc;
  logic                  w_last;

  assign w_len       = {r_len_hi, DIN};
  assign w_count_inc = r_count + 1'b1;
  assign w_last      = (32'(w_count_inc) == {16'd0, r_len});

  always_comb begin
    w_state_next = r_state;
    w_din_ready  = 1'b0;
    w_start      = 1'b0;
    w_wr         = 1'b0;
    w_set_done   = 1'b0;
    w_set_error  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_start      = 1'b1;
          w_state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        w_din_ready = 1'b1;
        w_accept    = DIN_VALID;
        if (DIN_VALID) w_state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_din_ready = 1'b1;
        w_accept    = DIN_VALID;
        if (DIN_VALID) begin
          if ({16'd0, w_len} > c_depth) begin
            w_set_error  = 1'b1;
            w_state_next = S_IDLE;
          end else if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_next = S_CSUM;
`else
            w_state_next = S_FINISH;
`endif
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_din_ready = 1'b1;
        w_accept    = DIN_VALID;
        if (DIN_VALID) begin
          w_wr = 1'b1;
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_next = S_CSUM;
`else
            w_state_next = S_FINISH;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        w_din_ready = 1'b1;
        w_accept    = DIN_VALID;
        if (DIN_VALID) begin
          if (DIN == r_csum) begin
            w_state_next = S_FINISH;
          end else begin
            w_set_error  = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
`endif
      S_FINISH: begin
        w_set_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_len_hi  <= 8'd0;
      r_len     <= 16'd0;
      r_count   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= 8'd0;
      r_wr_en   <= 1'b0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum    <= 8'd0;
`endif
    end else begin
      r_state <= w_state_next;
      r_wr_en <= w_wr;
      if (w_accept && (r_state == S_LEN_HI)) r_len_hi <= DIN;
      if (w_accept && (r_state == S_LEN_LO)) r_len    <= w_len;
      if (w_start) begin
        r_count <= '0;
      end else if (w_wr) begin
        r_count   <= w_count_inc;
        r_wr_addr <= r_count;
        r_wr_data <= DIN;
      end
`ifdef LOADER_CHECKSUM_EN
      if (w_start)   r_csum <= 8'd0;
      else if (w_wr) r_csum <= r_csum + DIN;
`endif
      if (w_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else if (w_set_done) begin
        r_done  <= 1'b1;
      end else if (w_set_error) begin
        r_error <= 1'b1;
      end
      // Hold drops one cycle after returning to IDLE, once the last write has retired.
      if (w_start)                  r_hold <= 1'b1;
      else if (r_state == S_IDLE)   r_hold <= 1'b0;
    end
  end

  assign DIN_READY  = w_din_ready;
  assign WR_ADDRESS = r_wr_addr;
  assign WR_DATA    = r_wr_data;
  assign WR_EN      = r_wr_en;
  assign CPU_HOLD   = r_hold;
  assign DONE       = r_done;
  assign ERROR      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_instr_mem_loader                                               |
// | Function : Directed self-checking bench for instr_mem_loader.                |
// | Revision : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] wr_address;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];

  instr_mem_loader #(.DEPTH(36), .ADDR_WIDTH(16)) dut (
    .CLK(clk), .RESET(rst), .START(start), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(din_ready), .WR_ADDRESS(wr_address), .WR_DATA(wr_data),
    .WR_EN(wr_en), .CPU_HOLD(cpu_hold), .DONE(done), .ERROR(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_address);
      log_data.push_back(wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no end, required $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    check("din_ready_before_byte", din_ready, 1);
    step();
    din_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_din_ready"}, din_ready, 0);
    check({pfx, "_wr_en"},     wr_en, 0);
    check({pfx, "_wr_addr"},   wr_address, 0);
    check({pfx, "_wr_data"},   wr_data, 0);
    check({pfx, "_cpu_hold"},  cpu_hold, 0);
    check({pfx, "_done"},      done, 0);
    check({pfx, "_error"},     error, 0);
  endtask

  initial begin
    int base;
    int bad;
    logic [7:0] sum;

    rst = 1'b1; start = 1'b0; din = 8'h00; din_valid = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Bytes offered in IDLE are not consumed.
    din = 8'hAA; din_valid = 1'b1;
    step(); step();
    check("idle_no_ready", din_ready, 0);
    check("idle_no_write", log_addr.size(), 0);
    din_valid = 1'b0;

    // Basic 3-byte load.
    pulse_start();
    check("start_hold", cpu_hold, 1);
    send(8'h00); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3);
`ifdef LOADER_CHECKSUM_EN
    send(8'h16);
`else
    check("basic_last_wr_en", wr_en, 1);
    check("basic_last_addr", wr_address, 2);
    check("basic_last_data", wr_data, 8'hC3);
`endif
    check("basic_done_not_yet", done, 0);
    step();
    check("basic_done", done, 1);
    check("basic_error", error, 0);
    check("basic_hold_still", cpu_hold, 1);
    check("basic_wr_en_low", wr_en, 0);
    step();
    check("basic_hold_low", cpu_hold, 0);
    check("basic_nwrites", log_addr.size(), 3);
    check("basic_w0", {log_addr[0], log_data[0]}, {16'd0, 8'hA1});
    check("basic_w1", {log_addr[1], log_data[1]}, {16'd1, 8'hB2});
    check("basic_w2", {log_addr[2], log_data[2]}, {16'd2, 8'hC3});

    // 2-byte load; wrong checksum when the checksum is built in.
    base = log_addr.size();
    pulse_start();
    check("start_clears_done", done, 0);
    send(8'h00); send(8'h02); send(8'h10); send(8'h20);
`ifdef LOADER_CHECKSUM_EN
    send(8'h31);
    check("csum_bad_error", error, 1);
    check("csum_bad_done", done, 0);
`else
    step();
    check("two_done", done, 1);
    check("two_error", error, 0);
`endif
    step();
    check("two_nwrites", log_addr.size() - base, 2);
    check("two_w1", {log_addr[base+1], log_data[base+1]}, {16'd1, 8'h20});

    // Oversize length.
    base = log_addr.size();
    pulse_start();
    check("start_clears_flags", {done, error}, 0);
    send(8'h00); send(8'h25);
    check("oversize_error", error, 1);
    check("oversize_done", done, 0);
    check("oversize_ready", din_ready, 0);
    check("oversize_hold", cpu_hold, 1);
    step();
    check("oversize_hold_low", cpu_hold, 0);
    check("oversize_no_write", log_addr.size() - base, 0);

    // Full-size load with valid gaps.
    base = log_addr.size();
    sum  = 8'h00;
    pulse_start();
    send(8'h00); send(8'h24);
    for (int i = 0; i < 36; i++) begin
      send(8'(i));
      sum = sum + 8'(i);
      if (i != 35) begin
        din = 8'hEE;
        step();
        check("gap_ready_held", din_ready, 1);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    din = 8'hEE;
    step();
    send(sum);
`else
    check("full_last_addr", wr_address, 35);
    check("full_last_data", wr_data, 8'h23);
`endif
    step();
    check("full_done", done, 1);
    check("full_error", error, 0);
    step();
    check("full_nwrites", log_addr.size() - base, 36);
    bad = 0;
    for (int i = 0; i < 36; i++)
      if (log_addr[base+i] !== 16'(i) || log_data[base+i] !== 8'(i)) bad++;
    check("full_content_errors", bad, 0);

    // Reset in the middle of the payload.
    pulse_start();
    send(8'h00); send(8'h05); send(8'h11); send(8'h22);
    check("mid_wr_en_before_reset", wr_en, 1);
    rst = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    base = log_addr.size();
    pulse_start();
    send(8'h00); send(8'h01); send(8'h5A);
`ifdef LOADER_CHECKSUM_EN
    send(8'h5A);
`endif
    step();
    check("after_reset_done", done, 1);
    step();
    check("after_reset_nwrites", log_addr.size() - base, 1);
    check("after_reset_w0", {log_addr[base], log_data[base]}, {16'd0, 8'h5A});

    // START during DATA is ignored.
    base = log_addr.size();
    pulse_start();
    send(8'h00); send(8'h02);
    start = 1'b1;
    send(8'h77);
    start = 1'b0;
    send(8'h88);
`ifdef LOADER_CHECKSUM_EN
    send(8'hFF);
`endif
    step();
    check("ignored_start_done", done, 1);
    check("ignored_start_error", error, 0);
    step();
    check("ignored_start_nwrites", log_addr.size() - base, 2);
    check("ignored_start_w0", {log_addr[base], log_data[base]}, {16'd0, 8'h77});
    check("ignored_start_w1", {log_addr[base+1], log_data[base+1]}, {16'd1, 8'h88});

    // Zero-length load.
    base = log_addr.size();
    pulse_start();
    send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("zero_finish_ready", din_ready, 0);
    check("zero_done_not_yet", done, 0);
    step();
    check("zero_done", done, 1);
    step();
    check("zero_hold_low", cpu_hold, 0);
    check("zero_no_write", log_addr.size() - base, 0);

    // RESET and START together: RESET wins.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_hold", cpu_hold, 0);
    check("rst_start_ready", din_ready, 0);
    check("rst_start_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
